// File: rtl/bip_acc_pkg.sv
// Shared definitions for the BIP accumulator with save stack: operation
// encodings and the signed-overflow rule used by the arithmetic path.
package bip_acc_pkg;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ADD  = 2'b01,
      OP_SUB  = 2'b10,
      OP_HOLD = 2'b11
   } accOp_e;

   localparam int ACC_W_DEFAULT = 16;
   localparam int DEPTH_DEFAULT = 4;

   // Two's-complement overflow from operand and result sign bits.
   function automatic logic signedOvf(input logic aMsb, input logic bMsb,
                                      input logic rMsb, input logic isSub);
      if (isSub)
         return (aMsb != bMsb) && (rMsb != aMsb);
      else
         return (aMsb == bMsb) && (rMsb != aMsb);
   endfunction

endpackage

// File: rtl/acc_stack_if.sv
// Operand, control and status bundle of the accumulator; master drives the
// operand/control side, slave is the accumulator itself.
interface acc_stack_if #(parameter int W = 16);
   import bip_acc_pkg::*;

   logic [W-1:0] SelA;
   logic         WrAcc;
   accOp_e       Op;
   logic         Push;
   logic         Pop;
   logic         ClrErr;
   logic [W-1:0] AccOut;
   logic         Zero;
   logic         Neg;
   logic         Carry;
   logic         Ovf;
   logic         Full;
   logic         Empty;
   logic         Err;

   modport master (
      output SelA, WrAcc, Op, Push, Pop, ClrErr,
      input  AccOut, Zero, Neg, Carry, Ovf, Full, Empty, Err
   );

   modport slave (
      input  SelA, WrAcc, Op, Push, Pop, ClrErr,
      output AccOut, Zero, Neg, Carry, Ovf, Full, Empty, Err
   );

endinterface

// File: rtl/acc_lifo.sv
// DEPTH x W save stack for the accumulator: pointer, Full/Empty, push/pop
// qualification and the sticky misuse flag.
module acc_lifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         Clock,
   input  logic         Reset_n,
   input  logic         pushReq,
   input  logic         popReq,
   input  logic         clrErr,
   input  logic [W-1:0] wrData,
   output logic [W-1:0] rdData,
   output logic         popOk,
   output logic         full,
   output logic         empty,
   output logic         err
);
   localparam int SPW = $clog2(DEPTH + 1);

   logic [SPW-1:0] spReg, spNext, topIdx;
   logic           errReg, errNext;
   logic           pushOk, errEvt;
   logic [W-1:0]   mem [DEPTH];

   assign full   = (spReg == SPW'(DEPTH));
   assign empty  = (spReg == '0);
   assign pushOk = pushReq & ~popReq & ~full;
   assign popOk  = popReq & ~pushReq & ~empty;
   assign errEvt = (pushReq & popReq) | (pushReq & ~popReq & full) |
                   (popReq & ~pushReq & empty);

   always_comb begin
      spNext = spReg;
      if (pushOk)
         spNext = spReg + SPW'(1);
      else if (popOk)
         spNext = spReg - SPW'(1);
      // A new error in the same cycle beats the clear request.
      errNext = errEvt ? 1'b1 : (clrErr ? 1'b0 : errReg);
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         spReg  <= '0;
         errReg <= 1'b0;
      end else begin
         spReg  <= spNext;
         errReg <= errNext;
      end
   end

   // Storage is deliberately unreset; it is never observable while empty.
   always_ff @(posedge Clock) begin
      for (int i = 0; i < DEPTH; i++)
         if (pushOk && spReg == SPW'(i))
            mem[i] <= wrData;
   end

   assign topIdx = empty ? '0 : spReg - SPW'(1);

   always_comb begin
      rdData = '0;
      for (int i = 0; i < DEPTH; i++)
         if (topIdx == SPW'(i))
            rdData = mem[i];
   end

   assign err = errReg;

endmodule

// File: rtl/acc_stack.sv
// W-bit accumulator with LOAD/ADD/SUB, registered carry/overflow and a LIFO
// context stack. Optional macro ACC_SAT_EN makes ADD/SUB saturate on overflow.
module acc_stack
   import bip_acc_pkg::*;
#(
   parameter int W     = ACC_W_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input logic        Clock,
   input logic        Reset_n,
   acc_stack_if.slave bus
);
   logic [W-1:0] accReg, accNext;
   logic         carryReg, carryNext;
   logic         ovfReg, ovfNext;
   logic [W:0]   sumW, diffW;
   logic         addOvf, subOvf;
   logic [W-1:0] addRes, subRes, rdData;
   logic         popOk, full, empty, err;

   acc_lifo #(.W(W), .DEPTH(DEPTH)) uLifo (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .pushReq (bus.Push),
      .popReq  (bus.Pop),
      .clrErr  (bus.ClrErr),
      .wrData  (accReg),
      .rdData  (rdData),
      .popOk   (popOk),
      .full    (full),
      .empty   (empty),
      .err     (err)
   );

   assign sumW   = {1'b0, accReg} + {1'b0, bus.SelA};
   assign diffW  = {1'b0, accReg} - {1'b0, bus.SelA};
   assign addOvf = signedOvf(accReg[W-1], bus.SelA[W-1], sumW[W-1], 1'b0);
   assign subOvf = signedOvf(accReg[W-1], bus.SelA[W-1], diffW[W-1], 1'b1);

`ifdef ACC_SAT_EN
   // Overflow direction follows the accumulator's sign: positive operand clamps high.
   assign addRes = addOvf ? (accReg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                          : sumW[W-1:0];
   assign subRes = subOvf ? (accReg[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                          : diffW[W-1:0];
`else
   assign addRes = sumW[W-1:0];
   assign subRes = diffW[W-1:0];
`endif

   always_comb begin
      accNext   = accReg;
      carryNext = carryReg;
      ovfNext   = ovfReg;
      if (popOk) begin
         accNext = rdData;
      end else if (bus.WrAcc) begin
         case (bus.Op)
            OP_LOAD: begin
               accNext   = bus.SelA;
               carryNext = 1'b0;
               ovfNext   = 1'b0;
            end
            OP_ADD: begin
               accNext   = addRes;
               carryNext = sumW[W];
               ovfNext   = addOvf;
            end
            OP_SUB: begin
               accNext   = subRes;
               carryNext = diffW[W];
               ovfNext   = subOvf;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         accReg   <= '0;
         carryReg <= 1'b0;
         ovfReg   <= 1'b0;
      end else begin
         accReg   <= accNext;
         carryReg <= carryNext;
         ovfReg   <= ovfNext;
      end
   end

   assign bus.AccOut = accReg;
   assign bus.Zero   = (accReg == '0);
   assign bus.Neg    = accReg[W-1];
   assign bus.Carry  = carryReg;
   assign bus.Ovf    = ovfReg;
   assign bus.Full   = full;
   assign bus.Empty  = empty;
   assign bus.Err    = err;

endmodule
